// File: rtl/sb_pkg.sv
// sb_pkg: shared types and helpers for the register-dependency scoreboard.
package sb_pkg;
    localparam int REG_IDX_W = 5;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic reg_idx_t idx_at(input logic [63:0] vec, input int i);
        return vec[i*REG_IDX_W +: REG_IDX_W];
    endfunction
endpackage

// File: rtl/sb_retire_count.sv
// sb_retire_count: per-register count of retire ports hitting that register this cycle.
module sb_retire_count
    import sb_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRET = 1,
    parameter int HW   = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]            ret_valid_i,
    input  logic [NRET*REG_IDX_W-1:0]  ret_dst_i,
    output logic [NREG-1:0][HW-1:0]    hits_o
);
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            hits_o[r] = '0;
            for (int j = 0; j < NRET; j++)
                if (r != 0 && ret_valid_i[j] && ret_dst_i[j*REG_IDX_W +: REG_IDX_W] == reg_idx_t'(r))
                    hits_o[r] = hits_o[r] + HW'(1);
        end
    end
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: saturating in-flight write counters per register with RAW/full issue gating.
// Define SB_RETIRE_BYPASS_EN to let same-cycle retires release a dependent issue.
module rf_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int NREAD = 2,
    parameter int NRET  = 1,
    parameter int CNT_W = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_issue_valid,
    output logic                        io_issue_ready,
    input  logic                        io_issue_rf_we,
    input  reg_idx_t                    io_issue_rf_dst,
    input  logic [NREAD*REG_IDX_W-1:0]  io_issue_rs,
    input  logic [NREAD-1:0]            io_issue_rs_used,
    input  logic [NRET-1:0]             io_ret_valid,
    input  logic [NRET*REG_IDX_W-1:0]   io_ret_rf_dst,
    input  logic                        io_flush,
    output logic [NREG-1:0]             io_busy,
    output logic                        io_err
);
    localparam int HW = $clog2(NRET + 1);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [NREG-1:0][HW-1:0]    hits;
    logic [NREG-1:0]            eff_busy;
    logic [63:0]                rs_ext;
    logic                       raw, full, fire, uflow;
    reg_idx_t                   rs;
    int                         s;

    sb_retire_count #(.NREG(NREG), .NRET(NRET), .HW(HW)) u_hits (
        .ret_valid_i (io_ret_valid),
        .ret_dst_i   (io_ret_rf_dst),
        .hits_o      (hits)
    );

    assign rs_ext = 64'(io_issue_rs);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
`ifdef SB_RETIRE_BYPASS_EN
            eff_busy[r] = int'(cnt_q[r]) > int'(hits[r]);
`else
            eff_busy[r] = cnt_q[r] != '0;
`endif
            io_busy[r] = cnt_q[r] != '0;
        end
    end

    always_comb begin
        raw = 1'b0;
        rs  = '0;
        for (int i = 0; i < NREAD; i++) begin
            rs = idx_at(rs_ext, i);
            if (io_issue_rs_used[i] && rs != '0 && eff_busy[rs])
                raw = 1'b1;
        end
        full           = io_issue_rf_we && io_issue_rf_dst != '0 && cnt_q[io_issue_rf_dst] == CMAX;
        io_issue_ready = !raw && !full && !io_flush;
        fire           = io_issue_valid && io_issue_ready;
    end

    // A full register can never fire, so the increment cannot wrap.
    always_comb begin
        uflow = 1'b0;
        s     = 0;
        for (int r = 0; r < NREG; r++) begin
            s = int'(cnt_q[r]) + ((fire && io_issue_rf_we && r != 0 && io_issue_rf_dst == reg_idx_t'(r)) ? 1 : 0);
            uflow    = uflow | (int'(hits[r]) > s);
            cnt_d[r] = io_flush ? '0 : (int'(hits[r]) > s) ? '0 : CNT_W'(s - int'(hits[r]));
        end
        err_d = err_q | (!io_flush && uflow);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign io_err = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed checks of rf_scoreboard with two retire ports.
module tb_rf_scoreboard;
    logic        clock = 1'b0;
    logic        reset;
    logic        valid, we, flush;
    logic [4:0]  dst;
    logic [9:0]  rs;
    logic [1:0]  rs_used, ret_valid;
    logic [9:0]  ret_dst;
    logic        ready, err;
    logic [31:0] busy;
    int          checks = 0;
    int          failures = 0;
`ifdef SB_RETIRE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clock = ~clock;

    rf_scoreboard #(.NREG(32), .NREAD(2), .NRET(2), .CNT_W(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_issue_valid   (valid),
        .io_issue_ready   (ready),
        .io_issue_rf_we   (we),
        .io_issue_rf_dst  (dst),
        .io_issue_rs      (rs),
        .io_issue_rs_used (rs_used),
        .io_ret_valid     (ret_valid),
        .io_ret_rf_dst    (ret_dst),
        .io_flush         (flush),
        .io_busy          (busy),
        .io_err           (err)
    );

    task automatic idle();
        valid = 0; we = 0; dst = 0; rs = 0; rs_used = 0;
        ret_valid = 0; ret_dst = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        idle();
        #1;
    endtask

    task automatic issue(input logic [4:0] d);
        valid = 1; we = 1; dst = d;
        tick();
    endtask

    task automatic retire(input logic v0, input logic [4:0] d0, input logic v1, input logic [4:0] d1);
        ret_valid = {v1, v0}; ret_dst = {d1, d0};
        tick();
    endtask

    task automatic test_reset();
        reset = 1; idle();
        repeat (2) @(negedge clock);
        #1;
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        reset = 0;
        tick();
    endtask

    task automatic test_issue_retire();
        valid = 1; we = 1; dst = 5; #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ir_ready got=%b exp=1", ready); end
        tick();
        checks++; if (busy !== 32'h20) begin failures++; $display("FAIL ir_busy_set got=%h exp=%h", busy, 32'h20); end
        retire(1, 5, 0, 0);
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL ir_busy_clr got=%h exp=%h", busy, 32'h0); end
    endtask

    task automatic test_bypass();
        issue(5);
        valid = 1; rs = {5'd0, 5'd5}; rs_used = 2'b01; #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL byp_raw got=%b exp=0", ready); end
        ret_valid = 2'b01; ret_dst = {5'd0, 5'd5}; #1;
        checks++; if (ready !== BYP) begin failures++; $display("FAIL byp_same_cycle got=%b exp=%b", ready, BYP); end
        tick();
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL byp_busy got=%h exp=%h", busy, 32'h0); end
        valid = 1; rs = {5'd0, 5'd5}; rs_used = 2'b01; #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL byp_next_cycle got=%b exp=1", ready); end
        tick();
    endtask

    task automatic test_full();
        issue(7); issue(7); issue(7);
        checks++; if (busy !== 32'h80) begin failures++; $display("FAIL full_busy got=%h exp=%h", busy, 32'h80); end
        valid = 1; we = 1; dst = 7; #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_blocked got=%b exp=0", ready); end
        ret_valid = 2'b01; ret_dst = {5'd0, 5'd7}; #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%b exp=0", ready); end
        tick();
        valid = 1; we = 1; dst = 7; #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL full_released got=%b exp=1", ready); end
        tick();
        retire(1, 7, 1, 7);
        checks++; if (busy !== 32'h80) begin failures++; $display("FAIL full_dual_ret got=%h exp=%h", busy, 32'h80); end
        retire(1, 7, 0, 0);
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL full_drain got=%h exp=%h", busy, 32'h0); end
    endtask

    task automatic test_x0();
        issue(3);
        valid = 1; we = 1; dst = 0; rs = {5'd3, 5'd0}; rs_used = 2'b01; #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", ready); end
        tick();
        checks++; if (busy !== 32'h8) begin failures++; $display("FAIL x0_busy got=%h exp=%h", busy, 32'h8); end
        retire(1, 3, 1, 0);
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL x0_ret_busy got=%h exp=%h", busy, 32'h0); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL x0_ret_err got=%b exp=0", err); end
    endtask

    task automatic test_underflow();
        issue(9); issue(9);
        checks++; if (busy !== 32'h200) begin failures++; $display("FAIL uf_busy got=%h exp=%h", busy, 32'h200); end
        retire(1, 9, 1, 9);
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL uf_dual_clear got=%h exp=%h", busy, 32'h0); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL uf_no_err got=%b exp=0", err); end
        retire(1, 9, 0, 0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_err got=%b exp=1", err); end
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL uf_clamp got=%h exp=%h", busy, 32'h0); end
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", err); end
    endtask

    task automatic test_flush_reset();
        issue(4); issue(6);
        checks++; if (busy !== 32'h50) begin failures++; $display("FAIL fl_busy got=%h exp=%h", busy, 32'h50); end
        flush = 1; valid = 1; we = 1; dst = 8; ret_valid = 2'b01; ret_dst = {5'd0, 5'd12}; #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fl_ready got=%b exp=0", ready); end
        tick();
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL fl_clear got=%h exp=%h", busy, 32'h0); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL fl_err_kept got=%b exp=1", err); end
        issue(10); issue(11);
        valid = 1; we = 1; dst = 12; #1;
        reset = 1; #1;
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL ar_busy got=%h exp=%h", busy, 32'h0); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ar_err got=%b exp=0", err); end
        tick();
        reset = 0;
        tick();
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL ar_after got=%h exp=%h", busy, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_issue_retire();
        test_bypass();
        test_full();
        test_x0();
        test_underflow();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
